// File: rtl/load_store_controller_if.sv
// Request, response and data-memory bus signals of the load/store controller.
// master = the controller, slave = the pipeline/memory side.
interface load_store_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_is_store;
  logic [2:0]              req_funct3;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;

  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_fault;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_controller.sv
// Single-outstanding load/store sequencer: aligns stores onto byte lanes, waits for
// grant/read data, and extracts/extends load results; misaligned/illegal accesses fault locally.
module load_store_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  load_store_controller_if.master bus
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LANES-1:0]      be_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  store_reg;
  logic                  fault_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            offset_reg;

  logic                  accept;
  logic [1:0]            offset;
  logic [1:0]            size;
  logic                  legal;
  logic                  misaligned;
  logic                  fault;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_rep_b;
  logic [DATA_WIDTH-1:0] wdata_rep_h;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  assign accept = bus.req_valid && bus.req_ready;
  assign offset = bus.req_addr[1:0];
  assign size   = bus.req_funct3[1:0];

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign misaligned = (size == 2'b01 && offset[0]) || (size == 2'b10 && offset != 2'b00);
  assign fault      = !legal || misaligned;

  always_comb begin
    be = '1;
    case (size)
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_rep_byte
      assign wdata_rep_b[gi*8 +: 8] = bus.req_wdata[7:0];
    end
    for (gi = 0; gi < LANES / 2; gi++) begin : g_rep_half
      assign wdata_rep_h[gi*16 +: 16] = bus.req_wdata[15:0];
    end
  endgenerate

  always_comb begin
    wdata = bus.req_wdata;
    case (size)
      2'b00:   wdata = wdata_rep_b;
      2'b01:   wdata = wdata_rep_h;
      default: wdata = bus.req_wdata;
    endcase
  end

  assign lane = bus.mem_rdata >> {offset_reg, 3'b000};

  always_comb begin
    load_ext = lane;
    case (funct3_reg)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = fault ? RESP : REQ;
      REQ:  if (bus.mem_gnt) state_next = store_reg ? RESP : WAIT;
      WAIT: if (bus.mem_rvalid) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // fault_reg and rdata_reg double as the response registers; both are cleared on leaving RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      be_reg     <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      store_reg  <= 1'b0;
      fault_reg  <= 1'b0;
      funct3_reg <= '0;
      offset_reg <= '0;
    end else if (accept) begin
      addr_reg   <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
      be_reg     <= be;
      wdata_reg  <= wdata;
      rdata_reg  <= '0;
      store_reg  <= bus.req_is_store;
      fault_reg  <= fault;
      funct3_reg <= bus.req_funct3;
      offset_reg <= offset;
    end else if (state_reg == WAIT && bus.mem_rvalid) begin
      rdata_reg  <= load_ext;
    end else if (state_reg == RESP) begin
      rdata_reg  <= '0;
      fault_reg  <= 1'b0;
    end
  end

  assign bus.req_ready = (state_reg == IDLE) && !rst;
  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_we    = (state_reg == REQ) && store_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_be    = be_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_fault = fault_reg;
endmodule

// File: tb/tb_load_store_controller.sv
// Randomized and directed bench for load_store_controller, checked cycle by cycle
// against an arithmetic model of the access rules.
module tb_load_store_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, expd);
    end
  endtask

  // Reference: access size in bytes, alignment by modulo, lanes by masks and shifts.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdw,
                                output bit flt, output logic [3:0] be_e,
                                output logic [31:0] wd_e, output logic [31:0] rd_e);
    int nbytes;
    int off;
    bit legal;
    logic [7:0]  bmask;
    logic [31:0] mask;
    logic [31:0] v;
    nbytes = 1 << f3[1:0];
    off    = int'(a[1:0]);
    legal  = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt    = !legal || ((off % nbytes) != 0);
    bmask  = 8'((1 << nbytes) - 1);
    bmask  = bmask << off;
    be_e   = bmask[3:0];
    for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = wd[8*(i % nbytes) +: 8];
    v    = rdw >> (8 * off);
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    v    = v & mask;
    if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
    rd_e = (flt || st) ? 32'h0 : v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdw,
                         input int gd, input int rd, input bit hold);
    bit flt;
    logic [3:0]  be_e;
    logic [31:0] wd_e, rd_e;
    int rsp_cyc;
    bit exp_mreq;
    model(st, f3, a, wd, rdw, flt, be_e, wd_e, rd_e);
    rsp_cyc = flt ? 1 : (st ? 2 + gd : 3 + gd + rd);
    $display("txn %s f3=%0d addr=%08h wdata=%08h rdata=%08h gnt_stall=%0d rv_stall=%0d -> fault=%0d be=%b result=%08h",
             st ? "ST" : "LD", f3, a, wd, rdw, gd, rd, flt, be_e, rd_e);
    check("req_ready_c0", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    for (int k = 1; k <= rsp_cyc + 1; k++) begin
      @(negedge clk);
      bus.req_valid    = hold && (k <= rsp_cyc);
      bus.req_is_store = 1'($urandom);
      bus.req_funct3   = 3'($urandom);
      bus.req_addr     = $urandom;
      bus.req_wdata    = $urandom;
      bus.mem_gnt      = 1'b0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = $urandom;
      exp_mreq = !flt && (k <= 1 + gd);
      check("mem_req", bus.mem_req, 32'(exp_mreq));
      if (exp_mreq) begin
        check("mem_we", bus.mem_we, 32'(st));
        check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        check("mem_be", bus.mem_be, be_e);
        if (st) check("mem_wdata", bus.mem_wdata, wd_e);
        bus.mem_gnt    = (k == 1 + gd);
        bus.mem_rvalid = 1'($urandom);
      end
      if (!flt && !st && k >= 2 + gd && k <= 2 + gd + rd) begin
        bus.mem_gnt = 1'($urandom);
        if (k == 2 + gd + rd) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdw;
        end
      end
      check("rsp_valid", bus.rsp_valid, 32'(k == rsp_cyc));
      check("req_ready", bus.req_ready, 32'(k == rsp_cyc + 1));
      if (k == rsp_cyc) begin
        check("rsp_fault", bus.rsp_fault, 32'(flt));
        check("rsp_rdata", bus.rsp_rdata, rd_e);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_mem_req", bus.mem_req, 0);
      check("idle_ready", bus.req_ready, 1);
      bus.mem_gnt    = spur ? 1'($urandom) : 1'b0;
      bus.mem_rvalid = spur ? 1'($urandom) : 1'b0;
      bus.mem_rdata  = $urandom;
    end
    @(negedge clk);
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("idle_rsp_valid_end", bus.rsp_valid, 0);
    check("idle_mem_req_end", bus.mem_req, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] legal_ld [5];
    logic [2:0] f3;
    bit st;
    legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fault", bus.rsp_fault, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;
    #1;
    check("rel_req_ready", bus.req_ready, 1);

    // Directed cases from the access rules
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 0, 0, 1'b0);
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 1, 2, 1'b0);
    run_txn(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0, 3, 0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
    run_txn(1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
    run_txn(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b1);
    run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    idle_cycles(4, 1'b1);

    // Reset while waiting for read data; the late rvalid must be ignored
    check("mid_ready_c0", bus.req_ready, 1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h0000_0080;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_mem_req", bus.mem_req, 1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("mid_wait_mem_req", bus.mem_req, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    check("mid_late_rsp_valid0", bus.rsp_valid, 0);
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("mid_late_rsp_valid1", bus.rsp_valid, 0);
    check("mid_late_rsp_rdata", bus.rsp_rdata, 0);
    check("mid_late_ready", bus.req_ready, 1);
    $display("txn reset-in-WAIT with late rvalid done");

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        f3 = st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      run_txn(st, f3, 32'($urandom_range(0, 1023)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 4) == 0) idle_cycles(2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_controller.md
# load_store_controller

Sequencing controller for the CPU data-memory port. Accepts one load/store at a time from the execute/memory stage, drives a word-aligned memory bus with byte enables, waits for grant and read data, then returns load results with byte/halfword lane extraction and sign/zero extension selected by funct3. Detects misaligned or illegal accesses and faults them without touching memory.

## Interface
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
- ADDR_WIDTH, 32, byte-address width

- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  controller idle and accepting
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, low-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and faults
- rsp_fault  out  1  misaligned or illegal funct3; qualified by rsp_valid
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  req_addr with bits [1:0] forced 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  full-word read data

## Operation
- Request fields latch on the req_valid && req_ready handshake. The mem_* outputs and rsp_* outputs are driven from the latched copies only.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_ready=1.
    - Accept, fault → RESP.
    - Accept, otherwise → REQ.
  - REQ: mem_req=1 with stable mem_* fields.
    - mem_gnt && store → RESP.
    - mem_gnt && load → WAIT.
    - No grant → stay in REQ.
  - WAIT: on mem_rvalid, capture the extended result → RESP.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE. There is no response backpressure.
- Fault conditions:
  - funct3 not in the legal set for the operation. Stores legal: 000/001/010. Loads legal: 000/001/010/100/101.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Byte accesses are never misaligned.
- Store lanes:
  - SB: wdata={4{b[7:0]}}, be=0001<<addr[1:0].
  - SH: wdata={2{h[15:0]}}, be=addr[1]?1100:0011.
  - SW: be=1111.
- Load extraction:
  - Lane = mem_rdata >> (8·addr[1:0]).
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- For loads: mem_we=0 and mem_be follows the same lane rule as stores.
- mem_gnt outside REQ and mem_rvalid outside WAIT are ignored.

## Timing
- Reset (rst high at a clk edge):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - rsp_valid=0, rsp_fault=0, rsp_rdata=0.
  - req_ready=0 while rst is high, 1 on the first cycle after release.
- Latency from the handshake edge (cycle 0):
  - Fault: rsp_valid in cycle 1.
  - Store with immediate grant: mem_req in cycle 1, rsp_valid in cycle 2.
  - Load with immediate grant and next-cycle rvalid: mem_req cycle 1, rvalid cycle 2, rsp_valid cycle 3.
  - Each grant-stall or rvalid-stall cycle adds one cycle.
- Throughput: one access in flight; req_ready=0 in REQ, WAIT and RESP. The next request is accepted in the IDLE cycle following RESP.
- mem_req is never deasserted in REQ before mem_gnt.
- rsp_rdata and rsp_fault are registered, valid only with rsp_valid, and reset to 0 when not in RESP.
- Reset mid-operation:
  - Transaction abandoned; mem_req low on the next cycle.
  - No rsp_valid is issued.
  - A late mem_rvalid arriving in IDLE is ignored.

## Test plan
- LB at addr 0x103, mem_rdata=0x80FF_1234, gnt in REQ, rvalid the next cycle:
  - mem_addr=0x100, mem_be=1000.
  - rsp_rdata=0xFFFF_FF80, rsp_fault=0, rsp_valid 3 cycles after the handshake.
- LHU at addr 0x202, mem_rdata=0x9ABC_0000 → mem_be=1100, rsp_rdata=0x0000_9ABC. LH at the same address → 0xFFFF_9ABC.
- SB at addr 0x11, wdata=0x0000_00A5, gnt held low 3 cycles:
  - mem_req stays high with stable fields: mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5.
  - rsp_valid one cycle after gnt; rsp_rdata=0.
- Faults: LW at 0x102, SH at 0x001, load funct3=011. Each gives:
  - mem_req never asserted.
  - rsp_valid with rsp_fault=1 in cycle 1, rsp_rdata=0.
- Back-to-back: SW at 0x40 then LW at 0x40:
  - Second request not accepted until IDLE.
  - Spurious mem_rvalid/mem_gnt pulses while IDLE produce no response.
- rst asserted in WAIT; mem_rvalid arrives 1 cycle after release:
  - No rsp_valid.
  - All outputs at reset values.
  - req_ready=1 after release.
